// File: rtl/encoder_tx_fsm.sv
// 64b/66b PCS transmit sequencer: enforces legal block ordering and
// substitutes error blocks, with a saturating count of error insertions.
module encoder_tx_fsm #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_TX_TYPE     = 4,
  parameter int LEN_ERR_COUNT   = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [LEN_TX_TYPE-1:0]     i_tx_type,
  input  logic [LEN_CODED_BLOCK-1:0] i_tx_coded,
  input  logic                       i_clear_count,
  output logic [LEN_CODED_BLOCK-1:0] o_tx_coded,
  output logic                       o_valid,
  output logic [2:0]                 o_state,
  output logic [LEN_ERR_COUNT-1:0]   o_error_count
);

  localparam logic [LEN_CODED_BLOCK-1:0] EBLOCK_T = {2'b10, 8'h1E, {8{7'h1E}}};
  localparam logic [LEN_CODED_BLOCK-1:0] LBLOCK_T = {2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0};
  localparam logic [LEN_ERR_COUNT-1:0]   CNT_ONE  = {{(LEN_ERR_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    TX_INIT = 3'd0,
    TX_C    = 3'd1,
    TX_D    = 3'd2,
    TX_T    = 3'd3,
    TX_E    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_D, CL_S, CL_C, CL_T, CL_E
  } class_t;

  state_t                     state_q, state_d, next_state;
  class_t                     blk_class;
  logic [LEN_CODED_BLOCK-1:0] coded_q, coded_d;
  logic                       valid_q, valid_d;
  logic [LEN_ERR_COUNT-1:0]   count_q, count_d;
  logic                       err_inc;

  function automatic logic [LEN_ERR_COUNT-1:0] sat_inc(input logic [LEN_ERR_COUNT-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Anything other than exactly one class bit is treated as invalid.
  always_comb begin
    blk_class = CL_E;
    case (i_tx_type)
      4'b1000: blk_class = CL_D;
      4'b0100: blk_class = CL_S;
      4'b0010: blk_class = CL_C;
      4'b0001: blk_class = CL_T;
      default: blk_class = CL_E;
    endcase
  end

  always_comb begin
    next_state = TX_E;
    case (state_q)
      TX_INIT, TX_C, TX_T: begin
        if (blk_class == CL_C)      next_state = TX_C;
        else if (blk_class == CL_S) next_state = TX_D;
      end
      TX_D: begin
        if (blk_class == CL_D)      next_state = TX_D;
        else if (blk_class == CL_T) next_state = TX_T;
      end
      TX_E: begin
        if (blk_class == CL_D)      next_state = TX_D;
        else if (blk_class == CL_C) next_state = TX_C;
        else if (blk_class == CL_T) next_state = TX_T;
      end
      default: next_state = TX_E;
    endcase
  end

  always_comb begin
    state_d = state_q;
    coded_d = coded_q;
    valid_d = 1'b0;
    count_d = count_q;
    err_inc = i_enable && (next_state == TX_E);

    if (i_enable) begin
      state_d = next_state;
      coded_d = (next_state == TX_E) ? EBLOCK_T : i_tx_coded;
      valid_d = 1'b1;
    end

    // A clear coinciding with an insertion still records that insertion.
    if (i_clear_count)
      count_d = err_inc ? CNT_ONE : '0;
    else if (err_inc)
      count_d = sat_inc(count_q);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= TX_INIT;
      coded_q <= LBLOCK_T;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      coded_q <= coded_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign o_tx_coded    = coded_q;
  assign o_valid       = valid_q;
  assign o_state       = state_q;
  assign o_error_count = count_q;

endmodule

// File: tb/tb_encoder_tx_fsm.sv
// Bench for encoder_tx_fsm: a table-driven reference model checked on every
// cycle, plus directed vectors with hand-computed expectations.
module tb_encoder_tx_fsm;

  localparam logic [65:0] LBLK = {2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0};
  localparam logic [65:0] EBLK = {2'b10, 8'h1E, {8{7'h1E}}};
  localparam logic [3:0]  TY_D = 4'b1000, TY_S = 4'b0100, TY_C = 4'b0010, TY_T = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  ty;
  logic [65:0] cin;
  logic        clr;
  logic [65:0] cout;
  logic        vld;
  logic [2:0]  st;
  logic [15:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  encoder_tx_fsm dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_tx_type(ty),
    .i_tx_coded(cin), .i_clear_count(clr), .o_tx_coded(cout),
    .o_valid(vld), .o_state(st), .o_error_count(cnt)
  );

  always #5 clk = ~clk;

  // Reference model: states 0..4 = INIT,C,D,T,E; classes 0..4 = D,S,C,T,E.
  int          nxt [5][5];
  int          m_state;
  logic [65:0] m_coded;
  logic        m_valid;
  int          m_count;

  function automatic int cls_of(input logic [3:0] t);
    if ($countones(t) != 1) return 4;
    if (t[3]) return 0;
    if (t[2]) return 1;
    if (t[1]) return 2;
    return 3;
  endfunction

  initial begin
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < 5; c++)
        nxt[s][c] = 4;
    nxt[0][2] = 1; nxt[0][1] = 2;
    nxt[1][2] = 1; nxt[1][1] = 2;
    nxt[2][0] = 2; nxt[2][3] = 3;
    nxt[3][2] = 1; nxt[3][1] = 2;
    nxt[4][0] = 2; nxt[4][2] = 1; nxt[4][3] = 3;
  end

  always @(posedge clk) begin
    int  ns;
    bit  inc;
    if (!rst) begin
      m_state = 0; m_coded = LBLK; m_valid = 1'b0; m_count = 0;
    end else begin
      inc = 1'b0;
      if (en) begin
        ns      = nxt[m_state][cls_of(ty)];
        inc     = (ns == 4);
        m_state = ns;
        m_coded = inc ? EBLK : cin;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (clr)                        m_count = inc ? 1 : 0;
      else if (inc && m_count < 65535) m_count = m_count + 1;
    end
    chk_on = 1'b1;
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_state", 66'(st),  66'(m_state));
      chk("model_coded", cout,     m_coded);
      chk("model_valid", 66'(vld), 66'(m_valid));
      chk("model_count", 66'(cnt), 66'(m_count));
    end
  end

  task automatic step(input logic e, input logic [3:0] t, input logic [65:0] d, input logic c);
    en = e; ty = t; cin = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  logic [65:0] pay [6];
  logic [3:0]  seq_ty [6];
  int          seq_st [6];

  initial begin
    rst = 1'b0; en = 1'b0; ty = 4'b0; cin = '0; clr = 1'b0;
    pay[0] = {2'b10, 64'h1111_2222_3333_4444};
    pay[1] = {2'b10, 64'h78AA_BBCC_DDEE_FF00};
    pay[2] = {2'b01, 64'hDEAD_BEEF_0123_4567};
    pay[3] = {2'b01, 64'h89AB_CDEF_FEDC_BA98};
    pay[4] = {2'b10, 64'h87FF_0000_0000_0000};
    pay[5] = {2'b10, 64'h1E00_0000_0000_0000};
    seq_ty = '{TY_C, TY_S, TY_D, TY_D, TY_T, TY_C};
    seq_st = '{1, 2, 2, 2, 3, 1};

    // 1: reset held for three clocks, then released with an idle cycle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 4'b0, '0, 1'b0);
    chk("rst_state", 66'(st), 66'd0);
    chk("rst_valid", 66'(vld), 66'd0);
    chk("rst_coded", cout, LBLK);
    chk("rst_count", 66'(cnt), 66'd0);

    // 2: legal packet sequence passes through unchanged
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq_ty[i], pay[i], 1'b0);
      chk("seq_state", 66'(st), 66'(seq_st[i]));
      chk("seq_coded", cout, pay[i]);
    end
    chk("seq_count", 66'(cnt), 66'd0);

    // 3: D while idle is an error, recovered by C
    step(1'b1, TY_D, pay[2], 1'b0);
    chk("err_state", 66'(st), 66'd4);
    chk("err_coded", cout, EBLK);
    chk("err_count", 66'(cnt), 66'd1);
    step(1'b1, TY_C, pay[5], 1'b0);
    chk("rec_state", 66'(st), 66'd1);
    chk("rec_coded", cout, pay[5]);

    // 4: invalid type mid-packet, then S keeps the error state
    step(1'b1, TY_S, pay[1], 1'b0);
    step(1'b1, 4'b0110, pay[2], 1'b0);
    chk("inv_state", 66'(st), 66'd4);
    chk("inv_coded", cout, EBLK);
    chk("inv_count", 66'(cnt), 66'd2);
    step(1'b1, TY_S, pay[1], 1'b0);
    chk("ee_state", 66'(st), 66'd4);
    chk("ee_count", 66'(cnt), 66'd3);

    // 5: stall mid-packet holds everything but valid
    step(1'b1, TY_D, pay[3], 1'b0);
    chk("dat_state", 66'(st), 66'd2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, TY_T, pay[0], 1'b0);
      chk("stall_valid", 66'(vld), 66'd0);
      chk("stall_state", 66'(st), 66'd2);
      chk("stall_coded", cout, pay[3]);
    end
    step(1'b1, TY_T, pay[4], 1'b0);
    chk("term_state", 66'(st), 66'd3);
    chk("term_coded", cout, pay[4]);
    chk("term_valid", 66'(vld), 66'd1);

    // 6: saturate the counter, clear with concurrent error, reset mid-packet
    step(1'b1, TY_D, pay[0], 1'b0);
    chk("sat_start", 66'(cnt), 66'd4);
    for (int i = 0; i < 65531; i++) step(1'b1, TY_S, pay[0], 1'b0);
    chk("sat_max", 66'(cnt), 66'd65535);
    step(1'b1, 4'b0000, pay[0], 1'b0);
    chk("sat_hold", 66'(cnt), 66'd65535);
    step(1'b1, TY_S, pay[0], 1'b1);
    chk("clr_inc", 66'(cnt), 66'd1);
    step(1'b0, TY_S, pay[0], 1'b1);
    chk("clr_idle", 66'(cnt), 66'd0);
    step(1'b1, TY_D, pay[2], 1'b0);
    chk("pre_rst_state", 66'(st), 66'd2);
    rst = 1'b0;
    step(1'b1, TY_D, pay[3], 1'b1);
    rst = 1'b1;
    chk("mid_rst_state", 66'(st), 66'd0);
    chk("mid_rst_coded", cout, LBLK);
    chk("mid_rst_valid", 66'(vld), 66'd0);
    step(1'b0, 4'b0, '0, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
